// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int DUTY_W    = 7;
    localparam int PCT_SCALE = 100;

endpackage

// File: rtl/pwm_capture_div.sv
// Restoring divider, one quotient bit per cycle; result offered on the last step.
module pwm_capture_div
    import pwm_capture_pkg::*;
#(
    parameter int NUM_W = 39,
    parameter int DEN_W = 32,
    parameter int Q_W   = DUTY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quot
);

    localparam int CW = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] dvd;
    logic [NUM_W-1:0] dvd_nxt;
    logic [DEN_W:0]   rem;
    logic [DEN_W:0]   rem_nxt;
    logic [DEN_W:0]   shifted;
    logic [DEN_W-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic             zero;
    logic             ge;

    always_comb begin
        shifted = {rem[DEN_W-1:0], dvd[NUM_W-1]};
        ge      = shifted >= {1'b0, dsr};
        rem_nxt = ge ? shifted - {1'b0, dsr} : shifted;
        dvd_nxt = {dvd[NUM_W-2:0], ge};
    end

    assign busy = cnt != '0;
    assign done = cnt == CW'(1);
    // A zero divisor would yield all ones; report 0 percent instead.
    assign quot = zero ? '0 : dvd_nxt[Q_W-1:0];

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            dvd  <= '0;
            rem  <= '0;
            dsr  <= '0;
            cnt  <= '0;
            zero <= 1'b0;
        end else if (start) begin
            dvd  <= num;
            rem  <= '0;
            dsr  <= den;
            cnt  <= CW'(NUM_W);
            zero <= den == '0;
        end else if (busy) begin
            dvd <= dvd_nxt;
            rem <= rem_nxt;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time, period and duty cycle of an asynchronous PWM input.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000000,
    parameter int SYNC_N  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  high_cnt,
    output logic [CNT_W-1:0]  period_cnt,
    output logic              meas_valid,
    output logic [DUTY_W-1:0] duty_pct,
    output logic              duty_valid,
    output logic              stuck,
    output logic              overrun
);

    localparam int NUM_W = CNT_W + DUTY_W;

    logic [SYNC_N-1:0] sync;
    logic              pwm_s;
    logic              pwm_d;
    logic              rise;
    logic              fall;
    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  lcnt;
    logic [CNT_W-1:0]  idle_cnt;
    logic              timeout;
    logic              close;
    logic              accept;
    logic [NUM_W-1:0]  num;
    logic              div_busy;
    logic              div_done;
    logic [DUTY_W-1:0] div_quot;

    assign pwm_s   = sync[SYNC_N-1];
    assign rise    = pwm_s & ~pwm_d;
    assign fall    = ~pwm_s & pwm_d;
    assign timeout = !rise && !fall && !stuck &&
                     idle_cnt == CNT_W'(TIMEOUT - 1);
    assign close   = rise && state == LOW;
    assign accept  = close && !div_busy;
    assign num     = NUM_W'(hcnt) * NUM_W'(PCT_SCALE);

    always_comb begin
        state_nxt = state;
        if (rise)
            state_nxt = HIGH;
        else if (timeout)
            state_nxt = IDLE;
        else if (fall && state == HIGH)
            state_nxt = LOW;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            pwm_d <= 1'b0;
            state <= IDLE;
        end else begin
            sync  <= {sync[SYNC_N-2:0], pwm_in};
            pwm_d <= pwm_s;
            state <= state_nxt;
        end
    end

    // Counters track sampled level so the rise cycle belongs to the new period.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt     <= '0;
            lcnt     <= '0;
            idle_cnt <= '0;
        end else begin
            if (rise) begin
                hcnt <= CNT_W'(1);
                lcnt <= '0;
            end else if (timeout) begin
                hcnt <= '0;
                lcnt <= '0;
            end else if (state != IDLE) begin
                hcnt <= hcnt + CNT_W'(pwm_s);
                lcnt <= lcnt + CNT_W'(!pwm_s);
            end
            if (rise || fall || stuck || timeout)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            high_cnt   <= '0;
            period_cnt <= '0;
            meas_valid <= 1'b0;
            duty_pct   <= '0;
            duty_valid <= 1'b0;
            stuck      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
            duty_valid <= div_done;
            if (div_done)
                duty_pct <= div_quot;
            if (rise)
                stuck <= 1'b0;
            if (accept) begin
                high_cnt   <= hcnt;
                period_cnt <= hcnt + lcnt;
                meas_valid <= 1'b1;
            end else if (close) begin
                overrun <= 1'b1;
            end
            if (timeout) begin
                stuck      <= 1'b1;
                high_cnt   <= '0;
                period_cnt <= '0;
                duty_pct   <= pwm_s ? DUTY_W'(PCT_SCALE) : '0;
                meas_valid <= 1'b1;
                duty_valid <= 1'b1;
            end
        end
    end

    pwm_capture_div #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W),
        .Q_W   (DUTY_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .abort (timeout),
        .num   (num),
        .den   (hcnt + lcnt),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: duty steps, timeout, overrun, reset mid-divide.
module tb_pwm_capture;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 200;
    localparam int LAT     = CNT_W + 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic [6:0]       duty_pct;
    logic             duty_valid;
    logic             stuck;
    logic             overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mv_n  = 0;
    int dv_n  = 0;
    int ov_n  = 0;
    int mv_cyc = 0;
    int dv_cyc = 0;
    logic [CNT_W-1:0] last_high = '0;
    logic [CNT_W-1:0] last_period = '0;
    logic [6:0]       last_duty = '0;

    pwm_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .SYNC_N  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .duty_pct   (duty_pct),
        .duty_valid (duty_valid),
        .stuck      (stuck),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (meas_valid) begin
                mv_n++;
                mv_cyc = cyc;
                last_high = high_cnt;
                last_period = period_cnt;
            end
            if (duty_valid) begin
                dv_n++;
                dv_cyc = cyc;
                last_duty = duty_pct;
            end
            if (overrun)
                ov_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pwm_run(input int hi, input int lo, input int n);
        repeat (n) begin
            pwm_in = 1'b1;
            tick(hi);
            pwm_in = 1'b0;
            tick(lo);
        end
    endtask

    task automatic check(input string tag, input logic [39:0] obs,
                         input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        pwm_in = 1'b0;
        tick(5);
        check("rst_high", 40'(high_cnt), 40'd0);
        check("rst_period", 40'(period_cnt), 40'd0);
        check("rst_duty", 40'(duty_pct), 40'd0);
        check("rst_flags", 40'({meas_valid, duty_valid, stuck, overrun}), 40'd0);
        reset = 1'b0;
        tick(2);
        check("rst_pulses", 40'(mv_n + dv_n + ov_n), 40'd0);

        // 25/75 for three periods
        pwm_run(25, 75, 3);
        check("p25_meas_n", 40'(mv_n), 40'd2);
        check("p25_high", 40'(last_high), 40'd25);
        check("p25_period", 40'(last_period), 40'd100);
        check("p25_duty_n", 40'(dv_n), 40'd2);
        check("p25_duty", 40'(last_duty), 40'd25);
        check("p25_lat", 40'(dv_cyc - mv_cyc), 40'(LAT));

        // Step to 90/10
        pwm_run(90, 10, 1);
        check("step_meas_n", 40'(mv_n), 40'd3);
        check("step_high", 40'(last_high), 40'd25);
        check("step_period", 40'(last_period), 40'd100);
        pwm_run(90, 10, 2);
        check("p90_meas_n", 40'(mv_n), 40'd5);
        check("p90_high", 40'(last_high), 40'd90);
        check("p90_period", 40'(last_period), 40'd100);
        check("p90_duty", 40'(last_duty), 40'd90);
        check("p90_duty_n", 40'(dv_n), 40'd5);

        // Line stuck high
        pwm_in = 1'b1;
        tick(TIMEOUT + 10);
        check("stk_flag", 40'(stuck), 40'd1);
        check("stk_high", 40'(high_cnt), 40'd0);
        check("stk_period", 40'(period_cnt), 40'd0);
        check("stk_duty", 40'(duty_pct), 40'd100);
        check("stk_meas_n", 40'(mv_n), 40'd7);
        check("stk_duty_n", 40'(dv_n), 40'd7);
        tick(50);
        check("stk_once_m", 40'(mv_n), 40'd7);
        check("stk_once_d", 40'(dv_n), 40'd7);
        pwm_in = 1'b0;
        tick(20);
        check("stk_fall", 40'(stuck), 40'd1);
        pwm_run(40, 60, 2);
        check("rec_flag", 40'(stuck), 40'd0);
        check("rec_meas_n", 40'(mv_n), 40'd8);
        check("rec_high", 40'(last_high), 40'd40);
        check("rec_period", 40'(last_period), 40'd100);
        check("rec_duty", 40'(last_duty), 40'd40);

        // Period of 10 cycles overruns the divider
        pwm_run(3, 7, 9);
        tick(50);
        check("ovr_n", 40'(ov_n), 40'd6);
        check("ovr_meas_n", 40'(mv_n), 40'd11);
        check("ovr_duty_n", 40'(dv_n), 40'd11);
        check("ovr_high", 40'(last_high), 40'd3);
        check("ovr_period", 40'(last_period), 40'd10);
        check("ovr_duty", 40'(last_duty), 40'd30);
        check("ovr_lat", 40'(dv_cyc - mv_cyc), 40'(LAT));

        // Reset while dividing
        pwm_in = 1'b1;
        tick(6);
        check("mid_meas_n", 40'(mv_n), 40'd12);
        check("mid_period", 40'(last_period), 40'd60);
        reset = 1'b1;
        pwm_in = 1'b0;
        tick(1);
        check("mid_high", 40'(high_cnt), 40'd0);
        check("mid_period0", 40'(period_cnt), 40'd0);
        check("mid_duty", 40'(duty_pct), 40'd0);
        check("mid_flags", 40'({meas_valid, duty_valid, stuck, overrun}), 40'd0);
        reset = 1'b0;
        tick(60);
        check("mid_no_duty", 40'(dv_n), 40'd11);
        check("mid_duty_hold", 40'(duty_pct), 40'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
